// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter for the PCI physical layer: 1-entry buffered valid/ready input,
// training commas after reset, then data words or idle commas back to back on the serial line.
module paralelo_serial_param #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'('hBC),
    parameter int unsigned       MIN_COMMAS = 4,
    parameter bit                MSB_FIRST  = 1'b1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             word_start,
    output logic             data_flag,
    output logic             training
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned CC_W  = $clog2(MIN_COMMAS + 1);

    typedef enum logic {StTrain, StActive} state_e;

    state_e           state_q, state_d;
    logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             first_q, first_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             data_out_q, data_out_d;
    logic             word_start_q, word_start_d;
    logic             data_flag_q, data_flag_d;

    logic             boundary;
    logic             load_data;
    logic             accept;
    logic [WIDTH-1:0] next_word;

    // first_q forces the edge right after reset release to be a word boundary.
    assign boundary  = first_q || (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign load_data = buf_full_q && (state_q == StActive);
    assign next_word = load_data ? buf_q : COMMA;
    assign ready_out = !buf_full_q && (state_q == StActive);
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d      = state_q;
        comma_cnt_d  = comma_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        first_d      = 1'b0;
        buf_full_d   = buf_full_q;
        buf_d        = buf_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        word_start_d = 1'b0;
        data_flag_d  = data_flag_q;

        if (boundary) begin
            bit_cnt_d    = '0;
            word_start_d = 1'b1;
            data_flag_d  = load_data;
            if (MSB_FIRST) begin
                data_out_d = next_word[WIDTH-1];
                shift_d    = next_word << 1;
            end else begin
                data_out_d = next_word[0];
                shift_d    = next_word >> 1;
            end
            if (load_data) begin
                buf_full_d = 1'b0;
            end
            // Only commas are loaded while training, so every boundary here counts one.
            if (state_q == StTrain) begin
                if (comma_cnt_q < CC_W'(MIN_COMMAS)) begin
                    comma_cnt_d = comma_cnt_q + CC_W'(1);
                end
                if (comma_cnt_q == CC_W'(MIN_COMMAS - 1)) begin
                    state_d = StActive;
                end
            end
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (MSB_FIRST) begin
                data_out_d = shift_q[WIDTH-1];
                shift_d    = shift_q << 1;
            end else begin
                data_out_d = shift_q[0];
                shift_d    = shift_q >> 1;
            end
        end

        // ready_out requires an empty buffer, so this never collides with the drain above.
        if (accept) begin
            buf_full_d = 1'b1;
            buf_d      = data_in;
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q      <= StTrain;
            comma_cnt_q  <= '0;
            bit_cnt_q    <= '0;
            first_q      <= 1'b1;
            buf_full_q   <= 1'b0;
            buf_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= 1'b0;
            word_start_q <= 1'b0;
            data_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            comma_cnt_q  <= comma_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            first_q      <= first_d;
            buf_full_q   <= buf_full_d;
            buf_q        <= buf_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            word_start_q <= word_start_d;
            data_flag_q  <= data_flag_d;
        end
    end

    assign data_out   = data_out_q;
    assign word_start = word_start_q;
    assign data_flag  = data_flag_q;
    assign training   = (state_q == StTrain);

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: an MSB-first lane and an LSB-first lane, with a scoreboard
// that deserialises each word and checks it against the queued expected word or the comma.
module tb_paralelo_serial_param;

    logic       clk_32f = 1'b0;
    logic       rst0, rst1;
    logic       valid0, valid1;
    logic [7:0] data0, data1;
    logic       rdy0, do0, ws0, df0, tr0;
    logic       rdy1, do1, ws1, df1, tr1;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         dws[2];
    logic [7:0] sh[2];
    int         nb[2];
    bit         col[2];
    logic       fl[2];
    bit         flok[2];

    always #5 clk_32f = ~clk_32f;

    paralelo_serial_param #(
        .WIDTH(8), .COMMA(8'hBC), .MIN_COMMAS(4), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk_32f(clk_32f), .reset(rst0), .valid_in(valid0), .data_in(data0),
        .ready_out(rdy0), .data_out(do0), .word_start(ws0), .data_flag(df0), .training(tr0)
    );

    paralelo_serial_param #(
        .WIDTH(8), .COMMA(8'hBC), .MIN_COMMAS(4), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk_32f(clk_32f), .reset(rst1), .valid_in(valid1), .data_in(data1),
        .ready_out(rdy1), .data_out(do1), .word_start(ws1), .data_flag(df1), .training(tr1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    // Words are collected in line order: first serial bit lands in bit 7.
    task automatic mon_step(input int l, input logic r, input logic d, input logic ws,
                            input logic df);
        logic [7:0] w;
        logic [7:0] e;
        if (r) begin
            col[l] = 1'b0;
            return;
        end
        if (ws) begin
            col[l]  = 1'b1;
            nb[l]   = 0;
            fl[l]   = df;
            flok[l] = 1'b1;
            sh[l]   = '0;
        end
        if (!col[l]) return;
        sh[l] = {sh[l][6:0], d};
        nb[l]++;
        if (df !== fl[l]) flok[l] = 1'b0;
        if (nb[l] == 8) begin
            col[l] = 1'b0;
            w = sh[l];
            check($sformatf("lane%0d flag_steady", l), {31'd0, flok[l]}, 32'd1);
            if (!fl[l]) begin
                check($sformatf("lane%0d comma", l), {24'd0, w},
                      (l == 0) ? 32'h0000_00BC : 32'h0000_003D);
            end else begin
                dws[l]++;
                if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL lane%0d unexpected_data: got %h expected no data word", l, w);
                end else begin
                    e = (l == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("lane%0d data", l), {24'd0, w}, {24'd0, e});
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_32f);
            mon_step(0, rst0, do0, ws0, df0);
            mon_step(1, rst1, do1, ws1, df1);
        end
    end

    task automatic write(input int l, input logic [7:0] w, input logic [7:0] e);
        int n;
        n = 0;
        while (((l == 0) ? !rdy0 : !rdy1) && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("write_ready_l%0d", l), {31'd0, (l == 0) ? rdy0 : rdy1}, 32'd1);
        if ((l == 0) ? !rdy0 : !rdy1) return;
        if (l == 0) begin
            valid0 = 1'b1;
            data0  = w;
            q0.push_back(e);
        end else begin
            valid1 = 1'b1;
            data1  = w;
            q1.push_back(e);
        end
        tick();
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    // Called right after lane 0 reset release; valid is held with DC while ready_out is low.
    task automatic train_phase(input string tag);
        logic [31:0] dv, wv, fv;
        int          tc, rc;
        bit          td, rd;
        dv = '0; wv = '0; fv = '0;
        tc = 0; rc = 0; td = 1'b0; rd = 1'b0;
        valid0 = 1'b1;
        data0  = 8'hDC;
        for (int i = 0; i < 32; i++) begin
            tick();
            dv = {dv[30:0], do0};
            wv = {wv[30:0], ws0};
            fv = {fv[30:0], df0};
            if (!td && tr0) tc++;
            else td = 1'b1;
            if (!rd && !rdy0) rc++;
            else rd = 1'b1;
            if (rdy0) valid0 = 1'b0;
        end
        valid0 = 1'b0;
        check({tag, " comma_bits"}, dv, 32'hBCBC_BCBC);
        check({tag, " word_start"}, wv, 32'h8080_8080);
        check({tag, " data_flag"}, fv, 32'h0000_0000);
        check({tag, " training_cycles"}, tc, 32'd24);
        check({tag, " not_ready_cycles"}, rc, 32'd24);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int seen;
        rst0 = 1'b1; rst1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0;
        repeat (2) @(posedge clk_32f);
        #1;
        check("rst data_out", {31'd0, do0}, 32'd0);
        check("rst word_start", {31'd0, ws0}, 32'd0);
        check("rst data_flag", {31'd0, df0}, 32'd0);
        check("rst training", {31'd0, tr0}, 32'd1);
        check("rst ready_out", {31'd0, rdy0}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Training commas, with DC offered while not ready.
        train_phase("t1");

        // Single word, then commas resume.
        write(0, 8'hAB, 8'hAB);
        repeat (24) tick();

        // Back-to-back words must leave no comma gap.
        fork
            begin
                write(0, 8'hAB, 8'hAB);
                write(0, 8'hCA, 8'hCA);
                write(0, 8'h12, 8'h12);
            end
            begin
                n = 0;
                while (!df0 && n < 30) begin
                    tick();
                    n++;
                end
                check("t3 start", {31'd0, df0}, 32'd1);
                cnt = 0;
                while (df0 && cnt < 40) begin
                    tick();
                    cnt++;
                end
                check("t3 contiguous", cnt, 32'd24);
            end
        join
        repeat (8) tick();

        // Offer DC while the buffer is full; 55 must go out untouched.
        write(0, 8'h55, 8'h55);
        valid0 = 1'b1;
        data0  = 8'hDC;
        n = 0;
        while (!rdy0 && n < 20) begin
            tick();
            n++;
        end
        valid0 = 1'b0;
        check("t4 ready_returns", {31'd0, rdy0}, 32'd1);
        repeat (20) tick();

        // Reset in the middle of FA with 33 buffered.
        write(0, 8'hFA, 8'hFA);
        n = 0;
        while (!(ws0 && df0) && n < 20) begin
            tick();
            n++;
        end
        check("t5 fa_start", {31'd0, ws0 && df0}, 32'd1);
        write(0, 8'h33, 8'h33);
        tick();
        tick();
        check("t5 fa_bit3", {31'd0, do0}, 32'd1);
        rst0 = 1'b1;
        q0.delete();
        #1;
        check("t5 rst data_out", {31'd0, do0}, 32'd0);
        check("t5 rst data_flag", {31'd0, df0}, 32'd0);
        check("t5 rst training", {31'd0, tr0}, 32'd1);
        check("t5 rst ready_out", {31'd0, rdy0}, 32'd0);
        seen = dws[0];
        tick();
        rst0 = 1'b0;
        train_phase("t5");
        repeat (40) tick();
        check("t5 no_stale_data", dws[0], seen);

        // LSB-first lane: 12 goes out as 0,1,0,0,1,0,0,0 (collected 48).
        write(1, 8'h12, 8'h48);
        repeat (24) tick();
        check("t6 lsb_words", dws[1], 32'd1);

        check("q0 drained", q0.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
